// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the RET/RTI unstack sequencer and the memory-stage push side.
// Stack layout constants must agree between the push and pop paths.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int PC_WIDTH   = 32;
  localparam int FLAG_WIDTH = 3;

  // Push order: slot 0 is pushed first, so it is popped last.
  localparam int PUSH_SLOT_PC_HI = 0;
  localparam int PUSH_SLOT_PC_LO = 1;
  localparam int PUSH_SLOT_FLAGS = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP_FLAGS = 3'd1,
    ST_POP_LO    = 3'd2,
    ST_POP_HI    = 3'd3,
    ST_DRAIN     = 3'd4
  } unstack_state_t;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FLAGS = 2'd1,
    TAG_LO    = 2'd2,
    TAG_HI    = 2'd3
  } pop_tag_t;

endpackage

// File: rtl/stack_unstack_controller.sv
// RET/RTI unstack sequencer: pops flags/pc_lo/pc_hi, captures each word one cycle
// after its pop is accepted, and presents the return PC and flags with load strobes.
module stack_unstack_controller
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_rti,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  mem_pop,
  output logic                  mem_read,
  output logic                  busy,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [FLAG_WIDTH-1:0] flags_out,
  output logic                  pc_load,
  output logic                  flags_load,
  output logic                  done,
  output unstack_state_t        dbg_state
);

  // Handshake: a pop is accepted on a rising edge where mem_pop && mem_ready;
  // mem_pop stays asserted until accepted, and data_in is sampled one cycle later.

  unstack_state_t              state;
  pop_tag_t                    tag_q;
  logic                        rti_q;
  logic [DATA_WIDTH-1:0]       pc_lo_q;
  logic [FLAG_WIDTH-1:0]       flags_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tag_q      <= TAG_NONE;
      rti_q      <= 1'b0;
      pc_lo_q    <= '0;
      flags_q    <= '0;
      pc_out     <= '0;
      flags_out  <= '0;
      mem_pop    <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      tag_q      <= TAG_NONE;

      // Capture the word returned for the pop accepted last cycle.
      case (tag_q)
        TAG_FLAGS: flags_q <= data_in[FLAG_WIDTH-1:0];
        TAG_LO:    pc_lo_q <= data_in;
        default:   ;
      endcase

      case (state)
        ST_IDLE: begin
          if (start) begin
            rti_q   <= is_rti;
            state   <= is_rti ? ST_POP_FLAGS : ST_POP_LO;
            mem_pop <= 1'b1;
          end
        end
        ST_POP_FLAGS: begin
          if (mem_ready) begin
            tag_q <= TAG_FLAGS;
            state <= ST_POP_LO;
          end
        end
        ST_POP_LO: begin
          if (mem_ready) begin
            tag_q <= TAG_LO;
            state <= ST_POP_HI;
          end
        end
        ST_POP_HI: begin
          if (mem_ready) begin
            tag_q   <= TAG_HI;
            state   <= ST_DRAIN;
            mem_pop <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // The high word arrives now; it goes straight into the presented PC.
          if (tag_q == TAG_HI) begin
            pc_out <= {data_in, pc_lo_q};
          end
          if (rti_q) begin
            flags_out <= flags_q;
          end
          done       <= 1'b1;
          pc_load    <= 1'b1;
          flags_load <= rti_q;
          state      <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          mem_pop <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = mem_pop;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_stack_unstack_controller.sv
// Bench for stack_unstack_controller: table of RET/RTI transactions (directed plus
// random) against a stack memory model, and a hand sequence for reset mid-RTI.
module tb_stack_unstack_controller;
  import cpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  is_rti = 1'b0;
  logic                  mem_ready = 1'b0;
  logic [DATA_WIDTH-1:0] data_in = '0;
  logic                  mem_pop, mem_read, busy, pc_load, flags_load, done;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [FLAG_WIDTH-1:0] flags_out;
  unstack_state_t        dbg_state;

  stack_unstack_controller dut (
    .clk(clk), .reset(reset), .start(start), .is_rti(is_rti),
    .mem_ready(mem_ready), .data_in(data_in), .mem_pop(mem_pop),
    .mem_read(mem_read), .busy(busy), .pc_out(pc_out), .flags_out(flags_out),
    .pc_load(pc_load), .flags_load(flags_load), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stack memory model: pop returns the most recently pushed word next cycle.
  logic [15:0] stack_q[$];
  int          plan[3];
  int          pop_idx = 0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  logic [15:0] pend_word = '0;

  always @(negedge clk) begin
    if (pend) data_in = pend_word;
    else      data_in = 16'($urandom);
    pend = 1'b0;
    if (mem_pop === 1'b1) begin
      if (stall_cnt > 0) begin
        mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_ready = 1'b1;
        pend_word = (stack_q.size() > 0) ? stack_q.pop_back() : 16'hDEAD;
        pend = 1'b1;
        pop_idx++;
        stall_cnt = (pop_idx < 3) ? plan[pop_idx] : 0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    bit          rti;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] flw;
    int          st[3];
    bit          inject;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] model_pc = '0;
  logic [2:0]  model_fl = '0;

  task automatic run_txn(input vec_t v, input int idx);
    int  k;
    bit  got;
    int  extra;
    logic [2:0] exp_fl;
    stack_q.delete();
    stack_q.push_back(v.hi);
    stack_q.push_back(v.lo);
    if (v.rti) stack_q.push_back(v.flw);
    plan = v.st;
    pop_idx = 0;
    stall_cnt = plan[0];
    start = 1'b1;
    is_rti = v.rti;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("hold_pc_at_start[%0d]", idx), pc_out, model_pc);
    chk($sformatf("hold_fl_at_start[%0d]", idx), 32'(flags_out), 32'(model_fl));
    k = 1;
    got = 0;
    while (k <= 40) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      chk($sformatf("busy_mid[%0d]", idx), 32'(busy), 32'd1);
      chk($sformatf("read_eq_pop[%0d]", idx), 32'(mem_read), 32'(mem_pop));
      start = v.inject && (k == 2);
      is_rti = start ? 1'b1 : 1'($urandom);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    exp_fl = v.rti ? v.flw[2:0] : model_fl;
    chk($sformatf("done_seen[%0d]", idx), 32'(got), 32'd1);
    chk($sformatf("latency[%0d]", idx), k, v.exp_lat);
    chk($sformatf("busy_at_done[%0d]", idx), 32'(busy), 32'd0);
    chk($sformatf("pc_load[%0d]", idx), 32'(pc_load), 32'd1);
    chk($sformatf("flags_load[%0d]", idx), 32'(flags_load), 32'(v.rti));
    chk($sformatf("pc_out[%0d]", idx), pc_out, v.exp_pc);
    chk($sformatf("flags_out[%0d]", idx), 32'(flags_out), 32'(exp_fl));
    chk($sformatf("pop_count[%0d]", idx), pop_idx, v.rti ? 3 : 2);
    model_pc = v.exp_pc;
    model_fl = exp_fl;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || pc_load !== 1'b0) extra++;
    end
    chk($sformatf("single_done[%0d]", idx), extra, 0);
    chk($sformatf("pc_hold_after[%0d]", idx), pc_out, model_pc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_fl"}, 32'(flags_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pop"}, 32'(mem_pop), 32'd0);
    chk({tag, "_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_strobes"}, {29'd0, done, pc_load, flags_load}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    // Directed entries.
    tbl[0] = '{rti: 0, hi: 16'hDCBA, lo: 16'hABCD, flw: 16'h0, st: '{0, 0, 0},
               inject: 0, exp_pc: 32'hDCBAABCD, exp_lat: 4};
    tbl[1] = '{rti: 1, hi: 16'hDCBA, lo: 16'hABCD, flw: 16'h0007, st: '{0, 0, 0},
               inject: 0, exp_pc: 32'hDCBAABCD, exp_lat: 5};
    tbl[2] = '{rti: 0, hi: 16'h1357, lo: 16'h2468, flw: 16'h0, st: '{0, 2, 0},
               inject: 0, exp_pc: 32'h13572468, exp_lat: 6};
    tbl[3] = '{rti: 0, hi: 16'h0F0F, lo: 16'hF0F0, flw: 16'h0, st: '{0, 0, 0},
               inject: 1, exp_pc: 32'h0F0FF0F0, exp_lat: 4};
    tbl[4] = '{rti: 0, hi: 16'hCAFE, lo: 16'hBEEF, flw: 16'h0, st: '{0, 0, 0},
               inject: 0, exp_pc: 32'hCAFEBEEF, exp_lat: 4};
    // Random entries: expectations from the stack rules.
    for (int i = 5; i < 16; i++) begin
      tbl[i].rti = 1'($urandom);
      tbl[i].hi = 16'($urandom);
      tbl[i].lo = 16'($urandom);
      tbl[i].flw = 16'($urandom);
      tbl[i].inject = 1'($urandom);
      for (int p = 0; p < 3; p++)
        tbl[i].st[p] = (p < (tbl[i].rti ? 3 : 2)) ? int'($urandom_range(0, 2)) : 0;
      tbl[i].exp_pc = {tbl[i].hi, tbl[i].lo};
      tbl[i].exp_lat = 4 + int'(tbl[i].rti) + tbl[i].st[0] + tbl[i].st[1] + tbl[i].st[2];
    end

    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("por");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_txn(tbl[i], i);

    // Reset mid-RTI, while in POP_LO with a nonzero PC on display.
    stack_q.delete();
    stack_q.push_back(16'h2222);
    stack_q.push_back(16'h1111);
    stack_q.push_back(16'h0005);
    plan = '{0, 0, 0};
    pop_idx = 0;
    stall_cnt = 0;
    start = 1'b1;
    is_rti = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_rti_state", 32'(dbg_state), 32'(ST_POP_LO));
    #2 reset = 1'b0;
    #1 reset_checks("async_rst");
    stack_q.delete();
    pend = 1'b0;
    stall_cnt = 0;
    model_pc = '0;
    model_fl = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_checks("post_rst");

    for (int i = 4; i < 16; i++) run_txn(tbl[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unstack_controller.md
Name: stack_unstack_controller

Overview:
Multi-cycle sequencer for RET/RTI. It issues consecutive stack pops to the memory stage and captures the returned 16-bit words one cycle after each accepted pop. It then reassembles the 32-bit return PC and, for RTI, the 3-bit flags. It sits beside the memory stage, drives the pop/read controls, and presents pc_out/flags_out with load strobes to fetch and to the flag register while stalling the front end.

Parameters:
DATA_WIDTH, 16, memory word width
PC_WIDTH, 32, program counter width (2 words)
FLAG_WIDTH, 3, flags restored on RTI (low bits of popped word)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request from the memory-stage control; sampled only in IDLE
is_rti  input  1  sampled with start; 1 = RTI (pop flags + PC), 0 = RET (PC only)
mem_ready  input  1  memory stage accepts the pop this cycle
data_in  input  DATA_WIDTH  read data; valid the cycle after an accepted pop
mem_pop  output  1  pop request (SP pre-increment is owned by the memory stage)
mem_read  output  1  equals mem_pop
busy  output  1  stall to fetch/decode; high from start acceptance until done
pc_out  output  PC_WIDTH  reassembled return PC
flags_out  output  FLAG_WIDTH  restored flags
pc_load  output  1  one-cycle strobe, pc_out valid
flags_load  output  1  one-cycle strobe, RTI only, coincident with pc_load
done  output  1  one-cycle completion pulse

Behaviour:
- Stack convention (matches push side): push order is pc[31:16], pc[15:0], then flags (interrupt only). Pops therefore return flags, pc_lo, pc_hi.
- States: IDLE, POP_FLAGS, POP_LO, POP_HI, DRAIN.
- IDLE: start=1 → POP_FLAGS if is_rti, else POP_LO. is_rti is latched into rti_q.
- POP_x states drive mem_pop=mem_read=1. They advance only when mem_ready=1: POP_FLAGS→POP_LO→POP_HI→DRAIN. With mem_ready=0 the state holds and mem_pop stays high.
- Tag register tag_q ∈ {NONE, FLAGS, LO, HI}. It is set to the kind of pop accepted this cycle, otherwise NONE.
- data_in capture each cycle according to tag_q:
  - FLAGS → flags_q ← data_in[FLAG_WIDTH-1:0]
  - LO → pc_q[15:0]
  - HI → pc_q[31:16]
  - NONE → no capture
- DRAIN: no pop. It captures HI and goes to IDLE, registering done=pc_load=1 and flags_load=rti_q for exactly the next cycle.
- Latency with mem_ready held high: RET done appears 4 cycles after the start edge; RTI appears 5 cycles after. Each mem_ready=0 cycle adds one cycle.
- busy = (state != IDLE). It falls in the same cycle done is high.
- start while not IDLE is ignored, with no queuing.
- pc_out/flags_out hold their last values until the next completed sequence. They are not cleared at start.
- Reset (asynchronous, any time, including mid-sequence):
  - state=IDLE, tag_q=NONE.
  - pc_out=0, flags_out=0.
  - all strobes, mem_pop, mem_read, busy = 0.
  - A pending capture is discarded.
- Data is never captured in a cycle where tag_q=NONE, even if data_in changes.

Decomposition:
- Shared package (cpu_pkg):
  - unstack_state_t enum
  - pop_tag_t enum
  - DATA_WIDTH/PC_WIDTH/FLAG_WIDTH constants
  - push-order constants, shared with the memory-stage push side
- No sub-module. A single FSM plus capture registers is natural.

Test Plan:
- Reset mid-RTI: assert reset=0 in POP_LO → outputs all 0 immediately (async), state IDLE. A later RET completes normally.
- RET: memory holds words 0xDCBA (pc_hi) and 0xABCD (pc_lo), start=1, is_rti=0, mem_ready=1 → two mem_pop cycles; done/pc_load high 4 cycles after start; pc_out=0xDCBAABCD; flags_load=0.
- RTI: stack holds flags word 0x0007 on top, then 0xABCD, 0xDCBA → three pops; done 5 cycles after start; pc_out=0xDCBAABCD, flags_out=3'b111, flags_load=1 together with pc_load.
- Backpressure: RET with mem_ready=0 for 2 cycles during POP_HI → mem_pop held high; done delayed by exactly 2 cycles; pc_out correct; junk data_in during stall not captured.
- start during busy: pulse start with is_rti=1 in POP_HI of a RET → ignored; RET completes with flags_load=0; a single done pulse.
